// File: rtl/b10_vote_arbiter_if.sv
// Channel between the vote stations, the b10 controller and b10_vote_arbiter.
// Signals:
//   req      stations -> arbiter  per-station request, held until ack
//   vote     stations -> arbiter  station i vote on [4i+3:4i]
//   ctr      b10 -> arbiter       1 = b10 ready, falls once the vote is captured
//   rts      arbiter -> b10       request-to-send, high exactly while transferring
//   v_out    arbiter -> b10       latched vote of the granted station
//   grant    arbiter -> stations  one-hot grant, zero when idle
//   ack      arbiter -> stations  one-cycle pulse on successful transfer
//   err      arbiter -> monitor   one-cycle pulse on watchdog abort
//   busy     arbiter -> monitor   transfer outstanding
//   xfer_cnt arbiter -> monitor   successful transfer count, wraps at 256
// Modports: master = arbiter side, slave = stations/b10 side.
interface b10_vote_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] vote;
  logic              ctr;
  logic              rts;
  logic [3:0]        v_out;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;
  logic [7:0]        xfer_cnt;

  modport master (
    input  req, vote, ctr,
    output rts, v_out, grant, ack, err, busy, xfer_cnt
  );

  modport slave (
    output req, vote, ctr,
    input  rts, v_out, grant, ack, err, busy, xfer_cnt
  );
endinterface

// File: rtl/b10_vote_arbiter.sv
// Round-robin arbiter sharing the b10 rts/ctr/v_in channel among NREQ stations.
// Waits in IDLE for ctr=1 with a pending request, grants the first requester at or
// after the priority pointer, drives its latched vote with rts=1, and returns to
// IDLE when b10 drops ctr (ack) or when rts has been high TIMEOUT cycles (err).
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    b10_vote_arbiter_if master modport (see interface header)
module b10_vote_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset,
  b10_vote_arbiter_if.master bus
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          NReqI = int'(NREQ);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NREQ - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [3:0]        v_out_q, v_out_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  logic [IdxW-1:0]   ptr_after;

  // First set request at or above ptr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NReqI; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % NReqI);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves past the served station on both success and abort.
  assign ptr_after = (gidx_q == IdxLast) ? '0 : gidx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    timer_d = timer_q;
    v_out_d = v_out_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ctr && win_found) begin
          state_d          = StXfer;
          gidx_d           = win_idx;
          timer_d          = '0;
          v_out_d          = bus.vote[{win_idx, 2'b00} +: 4];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      StXfer: begin
        // Success is checked first so a ctr fall on the last timer cycle still acks.
        if (!bus.ctr) begin
          state_d = StIdle;
          grant_d = '0;
          ack_d   = grant_q;
          cnt_d   = cnt_q + 8'd1;
          ptr_d   = ptr_after;
        end else if (timer_q == TmrLast) begin
          state_d = StIdle;
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = ptr_after;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      timer_q <= '0;
      v_out_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      timer_q <= timer_d;
      v_out_q <= v_out_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rts      = (state_q == StXfer);
  assign bus.busy     = (state_q == StXfer);
  assign bus.v_out    = v_out_q;
  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_b10_vote_arbiter.sv
// Scoreboard bench for b10_vote_arbiter: the driver steps a transaction-level
// reference model each cycle and queues the grant/ack/err events it predicts;
// an independent monitor pops and compares them as the DUT presents them.
module tb_b10_vote_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam int VW = 4 * N;

  localparam int EvGrant = 0;
  localparam int EvAck   = 1;
  localparam int EvErr   = 2;

  typedef struct {
    int         kind;
    int         at;
    logic [N-1:0] sel;
    logic [3:0] vout;
    logic [7:0] cnt;
  } ev_t;

  logic clock;
  logic reset;
  b10_vote_arbiter_if #(.NREQ(N)) bus ();

  b10_vote_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  ev_t q[$];

  // Reference model: a transfer in progress, its owner, how many cycles rts has
  // been high, the rotating priority start and the success count.
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_wait = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [3:0]  m_vote = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input int a, input int b);
    checks++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, b, cyc);
  endtask

  task automatic push(input int kind, input int s, input logic [3:0] v, input int cnt);
    ev_t e;
    e.kind = kind;
    e.at   = cyc + 1;
    e.sel  = '0;
    if (kind != EvErr) e.sel[s] = 1'b1;
    e.vout = v;
    e.cnt  = 8'(cnt % 256);
    q.push_back(e);
  endtask

  // Predicts what the next rising edge does with the inputs now applied.
  task automatic model_step();
    if (!m_busy) begin
      if (bus.ctr && bus.req != 0) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_ptr + k) % N;
          if (!m_busy && bus.req[s]) begin
            m_busy  = 1;
            m_owner = s;
            m_wait  = 1;
            m_vote  = bus.vote[4*s +: 4];
            push(EvGrant, s, m_vote, m_cnt);
          end
        end
      end
    end else if (!bus.ctr) begin
      m_cnt  = (m_cnt + 1) % 256;
      push(EvAck, m_owner, m_vote, m_cnt);
      m_ptr  = (m_owner + 1) % N;
      m_busy = 0;
    end else if (m_wait == TO) begin
      push(EvErr, m_owner, m_vote, m_cnt);
      m_ptr  = (m_owner + 1) % N;
      m_busy = 0;
    end else begin
      m_wait++;
    end
  endtask

  // One cycle of stimulus; b10 drops ctr once rts has been high 'hold' cycles,
  // or behaves randomly when hold < 0.
  task automatic step(input logic [N-1:0] r, input logic [VW-1:0] v, input int hold);
    @(negedge clock);
    reset    = 1'b1;
    bus.req  = r;
    bus.vote = v;
    if (hold < 0) begin
      if (m_busy) bus.ctr = ($urandom_range(0, 5) != 0);
      else        bus.ctr = ($urandom_range(0, 3) != 0);
    end else begin
      bus.ctr = m_busy ? (m_wait < hold) : 1'b1;
    end
    model_step();
  endtask

  // Monitor: matches DUT-presented events against the scoreboard queue.
  logic rts_prev = 1'b0;

  task automatic handle(input int kind);
    ev_t e;
    if (q.size() == 0 || q[0].at != cyc || q[0].kind != kind) begin
      fail("unexpected_event", kind, (q.size() == 0) ? -1 : q[0].kind);
    end else begin
      e = q.pop_front();
      if (kind == EvGrant) begin
        chk("grant", bus.grant, e.sel);
        chk("grant_vout", bus.v_out, e.vout);
        chk("grant_cnt", bus.xfer_cnt, e.cnt);
      end else if (kind == EvAck) begin
        chk("ack", bus.ack, e.sel);
        chk("ack_rts", bus.rts, 0);
        chk("ack_grant", bus.grant, 0);
        chk("ack_cnt", bus.xfer_cnt, e.cnt);
        chk("ack_vout", bus.v_out, e.vout);
      end else begin
        chk("err_ack", bus.ack, 0);
        chk("err_rts", bus.rts, 0);
        chk("err_cnt", bus.xfer_cnt, e.cnt);
      end
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].at < cyc) begin
      fail("missed_event_kind", q[0].kind, -1);
      void'(q.pop_front());
    end
    chk("ack_err_exclusive", {31'd0, (bus.ack != 0) && bus.err}, 0);
    chk("rts_eq_busy", bus.rts, bus.busy);
    chk("rts_eq_grant", bus.rts, {31'd0, bus.grant != 0});
    chk("grant_onehot0", {31'd0, $onehot0(bus.grant)}, 1);
    if (bus.rts && !rts_prev) handle(EvGrant);
    if (bus.ack != 0) handle(EvAck);
    if (bus.err) handle(EvErr);
    rts_prev = bus.rts;
  end

  logic [VW-1:0] v;

  initial begin
    reset    = 1'b0;
    bus.req  = 4'b1111;
    bus.ctr  = 1'b1;
    bus.vote = 16'h9abc;
    repeat (3) @(negedge clock);
    chk("reset_rts", bus.rts, 0);
    chk("reset_grant", bus.grant, 0);
    chk("reset_vout", bus.v_out, 0);
    chk("reset_cnt", bus.xfer_cnt, 0);
    chk("reset_ack_err", {bus.ack, bus.err}, 0);

    // Round robin with every station requesting: order 0,1,2,3,0.
    repeat (10) step(4'b1111, 16'h4321, 1);
    repeat (2) step(4'b0000, 16'h4321, 1);
    chk("rr_cnt", bus.xfer_cnt, 5);

    // Single transfer from station 2 with vote 0110.
    v = 16'h0600;
    repeat (6) step(4'b0100, v, 3);
    repeat (2) step(4'b0000, v, 1);

    // Watchdog: ctr stuck high, then station 1 gets the next grant.
    repeat (20) step(4'b0011, 16'h00a5, 100);
    repeat (4) step(4'b0000, 16'h00a5, 1);

    // Tie: ctr falls in the last allowed rts cycle.
    repeat (17) step(4'b0010, 16'h0070, TO);
    repeat (3) step(4'b0000, 16'h0070, 1);

    // Asynchronous reset in the middle of a transfer.
    repeat (3) step(4'b0100, 16'h0300, 100);
    #2;
    chk("pre_reset_rts", bus.rts, {31'd0, m_busy});
    reset = 1'b0;
    #1;
    chk("async_rts", bus.rts, 0);
    chk("async_grant", bus.grant, 0);
    chk("async_busy", bus.busy, 0);
    q.delete();
    m_busy = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    repeat (2) @(negedge clock);
    chk("async_ack_err", {bus.ack, bus.err}, 0);
    repeat (4) step(4'b1111, 16'h5555, 1);

    // Long back-to-back run so xfer_cnt wraps.
    repeat (600) step(4'b1111, VW'($urandom), 1);

    // Random traffic.
    repeat (3000) step(N'($urandom), VW'($urandom), -1);

    repeat (20) step(4'b0000, 16'h0000, 1);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/b10_vote_arbiter.md
# b10_vote_arbiter

Round-robin arbiter that lets `NREQ` vote stations share the single `rts`/`ctr`/`v_in` transfer channel of the b10 voting controller. It waits for b10 to signal readiness (`ctr`=1). It then grants one requesting station, drives that station's 4-bit vote with `rts`=1, and completes when b10 drops `ctr`. A watchdog aborts the transfer if b10 never responds. The block sits between the station front-ends and b10 and is the only driver of b10's `rts` and `v_in`.

## Interface
- `NREQ`, 4: number of requesting stations (2..8).
- `TIMEOUT`, 15: maximum number of cycles `rts` stays high waiting for `ctr` to fall (≥2).
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-station request; held high until that station's `ack`.
- `vote`  in  4*NREQ  station i vote on bits [4i+3:4i].
- `ctr`  in  1  from b10 `ctr`; 1 = b10 ready for a vote, falls when b10 has captured it.
- `rts`  out  1  to b10 `rts`.
- `v_out`  out  4  to b10 `v_in`; holds the latched vote of the granted station.
- `grant`  out  NREQ  one-hot grant; all zero when idle.
- `ack`  out  NREQ  one-cycle pulse to the served station on success.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `busy`  out  1  high while a transfer is outstanding (state XFER).
- `xfer_cnt`  out  8  count of successful transfers, wraps 255→0.

## Operation
- States: IDLE, XFER. On reset: IDLE, `rts`=0, `v_out`=0, `grant`=0, `ack`=0, `err`=0, `busy`=0, `xfer_cnt`=0, priority pointer `ptr`=0, timer=0.
- **IDLE:**
  - If `ctr`=1 and `req`≠0, select the first set `req` bit searching from `ptr` upward with wrap-around.
  - Next cycle: `grant` = one-hot of the winner g, `v_out` = `vote[4g+3:4g]`, `rts`=1, `busy`=1, timer=0, state XFER.
  - If `ctr`=0 or `req`=0, hold all outputs. `rts` stays 0 so b10 can raise `ctr`.
- **XFER**, sampled each cycle:
  - **Success:** if `ctr`=0, next cycle `rts`=0, `grant`=0, `busy`=0, `ack[g]`=1 for one cycle, `xfer_cnt`+1, `ptr`=(g+1) mod NREQ, state IDLE.
  - **Abort:** else if timer=TIMEOUT-1, next cycle `rts`=0, `grant`=0, `busy`=0, `err`=1 for one cycle, no `ack`, `xfer_cnt` unchanged, `ptr`=(g+1) mod NREQ, state IDLE.
  - **Wait:** otherwise timer+1.
- The vote is latched at grant. Later changes on `vote` or `req` of station g are ignored. Dropping `req[g]` mid-transfer does not cancel it, and `ack[g]` still pulses.
- A station whose `req` is still high in the cycle after its `ack` is treated as a new request. The `ptr` advance guarantees every other pending station is served first.
- `ack` and `err` are never both high. `grant` is at most one-hot. `rts`=1 if and only if state is XFER.

## Timing
- Grant latency: 1 cycle from sampling `ctr`=1 with `req`≠0 to `rts`/`grant`/`v_out` valid.
- Completion latency: 1 cycle from sampling `ctr`=0 in XFER to `ack` pulse and `rts`=0.
- Minimum spacing between grants: 2 cycles (XFER→IDLE, then IDLE must see `ctr`=1 again).
- Watchdog: `rts` is high for exactly TIMEOUT cycles on abort.
- Simultaneous events:
  - `ctr` falls in the same cycle the timer reaches TIMEOUT-1: success wins (`ack`, no `err`).
  - `ctr` and `req` sampled high in the same IDLE cycle: grant is issued.
- Reset mid-operation: asserting `reset` low clears all outputs asynchronously, without waiting for a clock edge. `rts` drops immediately, no `ack` or `err` is generated, and `ptr` returns to 0.
- `xfer_cnt` wraps from 255 to 0 on the 256th success with no other side effect.

## Test plan
- Reset: drive `reset`=0 with `req`=1111 and `ctr`=1 → `rts`=0, `grant`=0000, `v_out`=0, `xfer_cnt`=0. After release, first grant = 0001.
- Single transfer: `req`=0100, `vote[11:8]`=0110, `ctr`=1 → next cycle `grant`=0100, `rts`=1, `v_out`=0110. Drop `ctr` 2 cycles later → next cycle `ack`=0100 for one cycle, `rts`=0, `xfer_cnt`=1.
- Round-robin: `req`=1111 held, b10 model completing every transfer → grant order 0,1,2,3,0. Each `ack` is a single cycle. `xfer_cnt`=5.
- Watchdog: TIMEOUT=15, `req`=0011, `ctr` stuck at 1 → `rts` high exactly 15 cycles, then `err` pulse, no `ack`. Next grant goes to station 1.
- Tie: `ctr` falls in the 15th `rts`-high cycle → `ack` pulses, `err` stays 0.
- Async reset mid-XFER: `reset`=0 between clock edges while `rts`=1 → `rts`, `grant`, `busy` go 0 before the next edge. No `ack` or `err`. Subsequent grant starts from station 0.
